// File: rtl/pixel_word_packer.sv
// Purpose: packs four consecutive 8-bit pixels into one 32-bit word, tags the
//          final word of each frame and counts frames handed off downstream.
// Latency: the word appears one cycle after its 4th pixel is accepted.
// Backpressure: READY_OUT drops only when the 4th pixel is waiting and the
//          output register still holds an un-taken word, and always during clear.
// Ports: clk/rstn (sync active-low) | clear (sync flush, keeps frame_count)
//        pixel_in/VALID_IN/READY_OUT : pixel stream in
//        word_out/last_out/VALID_OUT/READY_IN : packed word stream out
//        frame_count : completed frames handed off (wraps)
module pixel_word_packer #(
  parameter int FRAME_PIXELS = 1024,
  parameter int FCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic [7:0]        pixel_in,
  input  logic              VALID_IN,
  output logic              READY_OUT,
  output logic [31:0]       word_out,
  output logic              VALID_OUT,
  input  logic              READY_IN,
  output logic              last_out,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int IDX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

  logic [1:0]       lane;     // bytes currently held in asm_buf
  logic [23:0]      asm_buf;  // lanes 0..2 of the word being assembled
  logic [IDX_W-1:0] pix_idx;  // index within the frame of the next pixel
  logic             accept;
  logic             handoff;
  logic             idx_last;

  // The 4th pixel bypasses asm_buf and goes straight into the output
  // register, so it can only be taken if that register is free or is being
  // emptied on this same edge.
  assign READY_OUT = !clear && ((lane != 2'd3) || !VALID_OUT || READY_IN);
  assign accept    = VALID_IN && READY_OUT;
  assign handoff   = VALID_OUT && READY_IN;
  assign idx_last  = (pix_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lane        <= 2'd0;
      asm_buf     <= 24'd0;
      pix_idx     <= '0;
      word_out    <= 32'd0;
      VALID_OUT   <= 1'b0;
      last_out    <= 1'b0;
      frame_count <= '0;
    end else if (clear) begin
      // Flush wins over any accept/handoff; the frame counter survives.
      lane      <= 2'd0;
      asm_buf   <= 24'd0;
      pix_idx   <= '0;
      word_out  <= 32'd0;
      VALID_OUT <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      if (handoff) begin
        VALID_OUT <= 1'b0;
        if (last_out) begin
          frame_count <= frame_count + FCNT_W'(1);
        end
      end
      if (accept) begin
        pix_idx <= idx_last ? '0 : pix_idx + IDX_W'(1);
        if (lane == 2'd3) begin
          // A load on the handoff edge overrides the clear of VALID_OUT above.
          word_out  <= {pixel_in, asm_buf};
          VALID_OUT <= 1'b1;
          last_out  <= idx_last;
          lane      <= 2'd0;
        end else begin
          case (lane)
            2'd0:    asm_buf[7:0]   <= pixel_in;
            2'd1:    asm_buf[15:8]  <= pixel_in;
            default: asm_buf[23:16] <= pixel_in;
          endcase
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
module tb_pixel_word_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear;
  logic [7:0]  pixel_in;
  logic        VALID_IN;
  logic        READY_OUT;
  logic [31:0] word_out;
  logic        VALID_OUT;
  logic        READY_IN;
  logic        last_out;
  logic [15:0] frame_count;

  pixel_word_packer #(.FRAME_PIXELS(1024), .FCNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .pixel_in(pixel_in), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
    .word_out(word_out), .VALID_OUT(VALID_OUT), .READY_IN(READY_IN),
    .last_out(last_out), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int tmo    = 0;

  logic [32:0] got_q[$];       // {last, word} of every handed-off word
  logic [7:0]  exp_pix[4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard capture plus output-hold check, using pre-edge values.
  logic        stall_prev = 1'b0;
  logic [32:0] held;
  always @(posedge clk) begin
    if (stall_prev && rstn && !clear) begin
      check("hold_word", word_out, held[31:0]);
      check("hold_last_valid", {30'd0, last_out, VALID_OUT}, {30'd0, held[32], 1'b1});
    end
    if (rstn && !clear && VALID_OUT && READY_IN) got_q.push_back({last_out, word_out});
    stall_prev = rstn && !clear && VALID_OUT && !READY_IN;
    held       = {last_out, word_out};
  end

  function automatic int count_last();
    int n = 0;
    foreach (got_q[i]) if (got_q[i][32]) n++;
    return n;
  endfunction

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic push(input logic [7:0] p);
    int n = 0;
    VALID_IN = 1'b1;
    pixel_in = p;
    #1;
    while (!READY_OUT && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) tmo++;
    @(negedge clk);
  endtask

  initial begin
    int i;
    int cyc;
    int mism;
    logic [31:0] ew;
    rstn = 1'b0; clear = 1'b0; pixel_in = 8'd0; VALID_IN = 1'b0; READY_IN = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_word", word_out, 32'd0);
    check("rst_valid_last", {30'd0, VALID_OUT, last_out}, 32'd0);
    check("rst_fcnt", {16'd0, frame_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_ready", {31'd0, READY_OUT}, 32'd1);

    // Bypass stream 0x00..0x07
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin VALID_IN = 1'b1; pixel_in = 8'(k); end
      else VALID_IN = 1'b0;
      #1;
      if (k < 8) check("byp_ready", {31'd0, READY_OUT}, 32'd1);
      check("byp_valid", {31'd0, VALID_OUT}, {31'd0, (k == 4 || k == 8)});
      if (k == 4) check("byp_word0", word_out, 32'h03020100);
      if (k == 8) check("byp_word1", word_out, 32'h07060504);
    end
    @(negedge clk); #1;
    check("byp_valid_end", {31'd0, VALID_OUT}, 32'd0);

    // Back-pressure 0x10..0x17
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      READY_IN = 1'b0; VALID_IN = 1'b1; pixel_in = 8'(8'h10 + k);
      #1;
      check("bp_ready", {31'd0, READY_OUT}, {31'd0, (k < 7)});
      if (k >= 4) check("bp_held_word", word_out, 32'h13121110);
    end
    @(negedge clk); #1;
    check("bp_still_stalled", {31'd0, READY_OUT}, 32'd0);
    @(negedge clk);
    READY_IN = 1'b1;
    #1;
    check("bp_ready_rise", {31'd0, READY_OUT}, 32'd1);
    check("bp_word_before", word_out, 32'h13121110);
    @(negedge clk);
    VALID_IN = 1'b0;
    #1;
    check("bp_valid_new", {31'd0, VALID_OUT}, 32'd1);
    check("bp_word_new", word_out, 32'h17161514);
    @(negedge clk); #1;
    check("bp_valid_end", {31'd0, VALID_OUT}, 32'd0);
    check("bp_count", got_q.size(), 32'd2);
    check("bp_q0", got_q[0][31:0], 32'h13121110);
    check("bp_q1", got_q[1][31:0], 32'h17161514);

    // Frame boundary: flush the offset left above, then one full frame
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    got_q.delete();
    for (int k = 0; k < 1024; k++) push(8'(k));
    VALID_IN = 1'b0;
    #1;
    check("frm_last_word", word_out, 32'hFFFEFDFC);
    check("frm_last_flag", {31'd0, last_out}, 32'd1);
    check("frm_fcnt_before", {16'd0, frame_count}, 32'd0);
    @(negedge clk); #1;
    check("frm_fcnt_after", {16'd0, frame_count}, 32'd1);
    check("frm_words", got_q.size(), 32'd256);
    check("frm_word0", got_q[0][31:0], 32'h03020100);
    check("frm_nlast", count_last(), 32'd1);
    check("frm_q255", {got_q[255][32], got_q[255][31:0]} >> 1, {1'b1, 32'hFFFEFDFC} >> 1);

    // Clear mid-word
    push(8'hAA);
    push(8'hBB);
    VALID_IN = 1'b0;
    clear = 1'b1;
    #1;
    check("clr_ready_low", {31'd0, READY_OUT}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_fcnt_kept", {16'd0, frame_count}, 32'd1);
    check("clr_valid", {31'd0, VALID_OUT}, 32'd0);
    got_q.delete();
    for (int k = 0; k < 1024; k++) push((k < 4) ? 8'(k + 1) : 8'(k));
    VALID_IN = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("clr_word0", got_q[0][31:0], 32'h04030201);
    check("clr_words", got_q.size(), 32'd256);
    check("clr_nlast", count_last(), 32'd1);
    check("clr_last_pos", {31'd0, got_q[255][32]}, 32'd1);
    check("clr_fcnt", {16'd0, frame_count}, 32'd2);

    // Reset mid-frame
    for (int k = 0; k < 500; k++) push(8'(k));
    VALID_IN = 1'b0;
    rstn = 1'b0;
    @(negedge clk); #1;
    check("mrst_word", word_out, 32'd0);
    check("mrst_valid_last", {30'd0, VALID_OUT, last_out}, 32'd0);
    check("mrst_fcnt", {16'd0, frame_count}, 32'd0);
    rstn = 1'b1;
    @(negedge clk); #1;
    check("mrst_ready", {31'd0, READY_OUT}, 32'd1);
    got_q.delete();
    for (int k = 0; k < 1024; k++) push(8'(k));
    VALID_IN = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_words", got_q.size(), 32'd256);
    check("mrst_nlast", count_last(), 32'd1);
    check("mrst_last_pos", {31'd0, got_q[255][32]}, 32'd1);
    check("mrst_fcnt", {16'd0, frame_count}, 32'd1);

    // Random ready/valid over 4 frames
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    got_q.delete();
    for (int k = 0; k < 4096; k++) exp_pix[k] = 8'($urandom);
    i = 0;
    cyc = 0;
    while ((i < 4096 || got_q.size() < 1024) && cyc < 30000) begin
      @(negedge clk);
      READY_IN = ($urandom_range(0, 3) != 0);
      if (i < 4096) begin
        VALID_IN = ($urandom_range(0, 3) != 0);
        pixel_in = exp_pix[i];
      end else VALID_IN = 1'b0;
      #1;
      if (VALID_IN && READY_OUT) i++;
      cyc++;
    end
    VALID_IN = 1'b0;
    READY_IN = 1'b1;
    @(negedge clk); #1;
    check("rnd_pixels", i, 32'd4096);
    check("rnd_words", got_q.size(), 32'd1024);
    mism = 0;
    foreach (got_q[w]) begin
      ew = {exp_pix[4*w+3], exp_pix[4*w+2], exp_pix[4*w+1], exp_pix[4*w]};
      if (got_q[w][31:0] !== ew || got_q[w][32] !== ((w % 256) == 255)) mism++;
    end
    check("rnd_stream", mism, 32'd0);
    check("rnd_fcnt", {16'd0, frame_count}, 32'd4);
    check("push_timeouts", tmo, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Output stage downstream of `data_proc`: consumes its 8-bit `pixel_out`/`VALID_OUT` stream and packs four consecutive pixels into one 32-bit word for the memory/bus writer. It also tags the final word of each frame and counts completed frames. Both sides use valid/ready handshakes, and the block applies back-pressure to `data_proc` only when a finished word cannot be handed off.

## Interface
Parameters:
- `FRAME_PIXELS`, 1024: pixels per frame (32x32). Must be a multiple of 4 and at least 4.
- `FCNT_W`, 16: width of the frame counter.

Ports:
- `clk`  in  1  single clock for the block.
- `rstn`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `clear`  in  1  synchronous flush. Drops the partial word and the pending output word, and restarts the frame.
- `pixel_in`  in  8  pixel from `data_proc`.
- `VALID_IN`  in  1  `pixel_in` is valid.
- `READY_OUT`  out  1  the block accepts `pixel_in` this cycle.
- `word_out`  out  32  packed word. The first pixel of the group is in [7:0], the fourth in [31:24].
- `VALID_OUT`  out  1  `word_out`/`last_out` are valid.
- `READY_IN`  in  1  downstream accepts the word.
- `last_out`  out  1  `word_out` holds pixel `FRAME_PIXELS-1`.
- `frame_count`  out  `FCNT_W`  number of completed frames handed off. Wraps modulo 2^`FCNT_W`.

## Operation
- Pixel accept: occurs on a rising edge with `VALID_IN && READY_OUT`.
- State registers:
  - `lane` (2 bits): count of bytes in the assembly buffer.
  - `asm` (24 bits): lanes 0-2.
  - `pix_idx` (0..`FRAME_PIXELS-1`).
  - Output register: `word_out`, `VALID_OUT`, `last_out`.
  - `frame_count`.
- Accept with `lane`<3: the pixel is stored in `asm` byte `lane`, then `lane`+1.
- Accept with `lane`==3: `{pixel_in, asm}` loads directly into `word_out`. In the same cycle:
  - `VALID_OUT`<=1 and `lane`<=0.
  - `last_out`<=(`pix_idx`==`FRAME_PIXELS-1`).
- `pix_idx` increments on every accept and wraps to 0 after `FRAME_PIXELS-1`.
- `READY_OUT` = `(lane != 3) || !VALID_OUT || READY_IN`. It is combinational, and no pixel is ever dropped.
- Handoff: occurs on `VALID_OUT && READY_IN`. On handoff, `VALID_OUT`<=0 unless a new word loads on the same edge. A simultaneous handoff and load keeps `VALID_OUT`=1 with the new word.
- `frame_count` increments on a handoff with `last_out`=1.
- Output hold: while `VALID_OUT && !READY_IN`, `word_out` and `last_out` stay stable.
- `clear`=1 sets `lane`, `pix_idx`, `asm`, `VALID_OUT`, `last_out` and `word_out` to 0.
  - `frame_count` is kept.
  - `clear` overrides any accept or handoff in the same cycle: no `frame_count` increment, and `READY_OUT` is forced to 0 while `clear`=1.
- `VALID_IN` with `READY_OUT`=0: the pixel is not taken, and the upstream must hold it.

## Timing
- Reset: `rstn`=0 at a rising edge zeroes every register. `READY_OUT`=1 from the first cycle after reset with `rstn`=1.
- Reset values: `word_out`=0, `VALID_OUT`=0, `last_out`=0, `frame_count`=0.
- Reset mid-word or mid-frame discards all partial state.
- Latency: the 4th pixel accepted at edge N gives `VALID_OUT`=1 with its word after edge N, i.e. 1 cycle.
- Throughput: 1 pixel/cycle sustained with `READY_IN`=1. The output is valid every 4th cycle.
- Back-pressure when `READY_IN`=0:
  - 3 more pixels are accepted into `asm`.
  - `READY_OUT` drops only at `lane`==3 with `VALID_OUT`=1.
  - `READY_OUT` rises combinationally in the cycle `READY_IN` returns, so the stalled handoff and load occur on the same edge.
- `frame_count` updates the cycle after the last-word handoff edge.
- Frame wrap: the pixel after index `FRAME_PIXELS-1` starts the next frame at index 0 with no gap cycle.

## Test plan
- **Bypass stream:** reset, then pixels 0x00..0x07 with `READY_IN`=1.
  - Words 0x03020100 and 0x07060504, each valid for 1 cycle, 1 cycle after the 4th pixel.
  - `READY_OUT` stays 1 throughout.
- **Back-pressure:** `READY_IN`=0, feed 0x10..0x17.
  - `word_out`=0x13121110 is held.
  - `READY_OUT` falls after 0x16 is accepted and 0x17 waits.
  - Raise `READY_IN`: 0x17161514 follows on the next cycle, with no loss or duplication.
- **Frame boundary:** 1024 pixels with value = index[7:0].
  - The 256th word is 0xFFFEFDFC with `last_out`=1.
  - `frame_count` goes 0→1, and the next pixel starts at `pix_idx` 0.
- **Clear mid-word:** send 0xAA, 0xBB, pulse `clear`, then send 0x01..0x04.
  - Output is 0x04030201 and `last_out` timing restarts.
  - `frame_count` is unchanged.
- **Reset mid-frame:** assert `rstn`=0 after 500 pixels.
  - All outputs read 0.
  - The next 1024 pixels produce exactly one `last_out`, on the 256th word.
- **Random ready/valid:** 4 frames with randomly toggled `VALID_IN`/`READY_IN`.
  - The word stream matches the reference packing.
  - `frame_count`=4, and no `word_out` change occurs while `VALID_OUT && !READY_IN`.
